// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared constants, state encoding and geometry helpers for the calculator datapath
package calc_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of chunk passes needed for one operation.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index register width; a single-chunk unit still keeps a 1-bit index.
    function automatic int calc_idx_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Geometry sanity check evaluated at elaboration by every user of the unit.
    function automatic bit calc_geometry_ok(input int width, input int chunk);
        return (chunk >= 1) && (width >= 2) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// rtl/chunk_adder.sv - combinational CHUNK-bit ripple adder built from full adder cells
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[CHUNK];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/signed_addsub_serial.sv
// rtl/signed_addsub_serial.sv - multi-cycle signed add/subtract, CHUNK bits per clock
module signed_addsub_serial
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IW     = calc_idx_width(WIDTH, CHUNK);
    localparam logic [IW-1:0]    LAST_IDX   = IW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if (!calc_geometry_ok(WIDTH, CHUNK)) begin : g_bad_geometry
        $error("signed_addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;          // b already inverted for subtract
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
    logic             chunk_cout;
    logic [WIDTH-1:0] merged;
    int               shamt;

    // Select the active chunk of both operands and splice its sum into the shadow.
    always_comb begin
        shamt   = CHUNK * int'(idx_q);
        chunk_a = CHUNK'(a_q >> shamt);
        chunk_b = CHUNK'(b_q >> shamt);
        merged  = (shadow_q & ~(CHUNK_MASK << shamt)) | (WIDTH'(chunk_sum) << shamt);
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry_q),
        .sum  (chunk_sum),
        .cout (chunk_cout)
    );

    // Next-state: capture operands in IDLE, walk the chunks in RUN, publish on the last one.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = (op == OP_SUB) ? ~b : b;
                    carry_d  = op;
                    idx_d    = '0;
                    shadow_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                shadow_d = merged;
                carry_d  = chunk_cout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    result_d = merged;
                    cout_d   = chunk_cout;
                    ovf_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (merged[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d   = (merged == '0);
                    neg_d    = merged[WIDTH-1];
                    done_d   = 1'b1;
                    idx_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            shadow_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign neg      = neg_q;

endmodule

// File: tb/tb_signed_addsub_serial.sv
// tb/tb_signed_addsub_serial.sv - scoreboard bench for three geometries of signed_addsub_serial
`timescale 1ns/1ps
module tb_signed_addsub_serial;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    typedef struct packed {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  res;
        logic [3:0]  cvzn;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [15:0] a_in;
    logic [15:0] b_in;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    // Reference: integer arithmetic with overflow judged against the signed range.
    function automatic exp_t model(input int w, input logic sub, input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint mask, ua, ub, u, sa, sb, t, lim;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        u    = sub ? (ua + ((~ub) & mask) + 1) : (ua + ub);
        sa   = (((ua >> (w - 1)) & 1) != 0) ? ua - (longint'(1) << w) : ua;
        sb   = (((ub >> (w - 1)) & 1) != 0) ? ub - (longint'(1) << w) : ub;
        t    = sub ? (sa - sb) : (sa + sb);
        lim  = longint'(1) << (w - 1);
        e.res = 16'(u & mask);
        e.c   = ((u >> w) & 1) != 0;
        e.v   = (t >= lim) || (t < -lim);
        e.z   = (u & mask) == 0;
        e.n   = ((u >> (w - 1)) & 1) != 0;
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W   = (g == 2) ? 16 : 8;
        localparam int C   = (g == 1) ? 8 : 4;
        localparam int LAT = W / C;

        logic         busy, done, cout, overflow, zero, neg;
        logic [W-1:0] result;
        exp_t         q[$];
        exp_t         held = '0;
        int           m_cnt = 0;
        bit           m_done = 1'b0;
        int           accepted = 0;

        signed_addsub_serial #(.WIDTH(W), .CHUNK(C)) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .op       (op),
            .a        (a_in[W-1:0]),
            .b        (b_in[W-1:0]),
            .busy     (busy),
            .done     (done),
            .result   (result),
            .cout     (cout),
            .overflow (overflow),
            .zero     (zero),
            .neg      (neg)
        );

        always @(negedge clk) begin
            if (m_done) begin
                tests_run++;
                if (q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL cfg%0d scoreboard: done with no pending op, required one queued", g);
                end else begin
                    held = q.pop_front();
                end
            end
            tests_run++;
            if (busy !== (m_cnt > 0) || done !== m_done) begin
                tests_failed++;
                $display("FAIL cfg%0d handshake: busy=%b done=%b, required busy=%b done=%b",
                         g, busy, done, (m_cnt > 0), m_done);
            end
            tests_run++;
            if (result !== held.res[W-1:0] || {cout, overflow, zero, neg} !== {held.c, held.v, held.z, held.n}) begin
                tests_failed++;
                $display("FAIL cfg%0d outputs: result=%h cvzn=%b%b%b%b, required result=%h cvzn=%b%b%b%b",
                         g, result, cout, overflow, zero, neg, held.res[W-1:0], held.c, held.v, held.z, held.n);
            end
            if (rst) begin
                m_cnt  = 0;
                m_done = 1'b0;
                q.delete();
                held   = '0;
            end else if (m_cnt == 0) begin
                m_done = 1'b0;
                if (start) begin
                    q.push_back(model(W, op, a_in, b_in));
                    m_cnt = LAT;
                    accepted++;
                end
            end else begin
                m_cnt--;
                m_done = (m_cnt == 0);
            end
        end
    end

    task automatic issue(input logic sub, input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        start = 1'b1; op = sub; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom); op = 1'($urandom);
    endtask

    task automatic wait_done0(output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (cfg[0].done) seen = 1'b1;
            else if (cfg[0].busy) busy_cycles++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests_run++;
        if ({cfg[0].busy, cfg[0].done, cfg[0].result, cfg[0].cout, cfg[0].overflow, cfg[0].zero, cfg[0].neg} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b result=%h, required all zero",
                     cfg[0].busy, cfg[0].done, cfg[0].result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_directed;
        dir_t tbl[5];
        int   bc;
        bit   seen;
        tbl[0] = '{sub: 1'b0, a: 16'd5,      b: 16'd3,      res: 8'h08, cvzn: 4'b0000};
        tbl[1] = '{sub: 1'b0, a: 16'd100,    b: 16'd50,     res: 8'h96, cvzn: 4'b0101};
        tbl[2] = '{sub: 1'b1, a: 16'hFF80,   b: 16'd1,      res: 8'h7F, cvzn: 4'b1100};
        tbl[3] = '{sub: 1'b0, a: 16'hFFFD,   b: 16'hFFFB,   res: 8'hF8, cvzn: 4'b1001};
        tbl[4] = '{sub: 1'b1, a: 16'd0,      b: 16'hFF80,   res: 8'h80, cvzn: 4'b0101};
        for (int i = 0; i < 5; i++) begin
            issue(tbl[i].sub, tbl[i].a, tbl[i].b);
            wait_done0(bc, seen);
            tests_run++;
            if (!seen) begin
                tests_failed++;
                $display("FAIL directed%0d timeout: no done within 20 cycles, required done", i);
            end
            tests_run++;
            if (bc != 2) begin
                tests_failed++;
                $display("FAIL directed%0d latency: %0d busy cycles, required 2", i, bc);
            end
            tests_run++;
            if (cfg[0].result !== tbl[i].res ||
                {cfg[0].cout, cfg[0].overflow, cfg[0].zero, cfg[0].neg} !== tbl[i].cvzn) begin
                tests_failed++;
                $display("FAIL directed%0d values: result=%h cvzn=%b%b%b%b, required result=%h cvzn=%b",
                         i, cfg[0].result, cfg[0].cout, cfg[0].overflow, cfg[0].zero, cfg[0].neg,
                         tbl[i].res, tbl[i].cvzn);
            end
        end
    endtask

    task automatic test_back_to_back;
        int bc;
        bit seen;
        issue(1'b1, 16'd7, 16'd7);
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; a_in = 16'd1; b_in = 16'd2;
        @(negedge clk);
        tests_run++;
        if (cfg[0].done !== 1'b1 || cfg[0].result !== 8'h00 ||
            {cfg[0].cout, cfg[0].overflow, cfg[0].zero, cfg[0].neg} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL b2b_first: done=%b result=%h cvzn=%b%b%b%b, required done=1 result=00 cvzn=1010",
                     cfg[0].done, cfg[0].result, cfg[0].cout, cfg[0].overflow, cfg[0].zero, cfg[0].neg);
        end
        @(posedge clk); #1;
        start = 1'b0; a_in = 16'hBEEF; b_in = 16'h1234;
        wait_done0(bc, seen);
        tests_run++;
        if (!seen || bc != 2 || cfg[0].result !== 8'h03) begin
            tests_failed++;
            $display("FAIL b2b_second: seen=%b busy_cycles=%0d result=%h, required seen=1 busy_cycles=2 result=03",
                     seen, bc, cfg[0].result);
        end
    endtask

    task automatic test_start_while_busy;
        int bc;
        bit seen;
        issue(1'b0, 16'd5, 16'd3);
        start = 1'b1; op = 1'b0; a_in = 16'd9; b_in = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done0(bc, seen);
        tests_run++;
        if (!seen || cfg[0].result !== 8'h08) begin
            tests_failed++;
            $display("FAIL busy_start: seen=%b result=%h, required seen=1 result=08", seen, cfg[0].result);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (cfg[0].busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start_queued: busy=%b, required 0", cfg[0].busy);
        end
    endtask

    task automatic test_reset_abort;
        int done_seen;
        repeat (4) @(posedge clk);
        issue(1'b0, 16'd5, 16'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({cfg[0].busy, cfg[0].done, cfg[0].result, cfg[0].cout, cfg[0].overflow, cfg[0].zero, cfg[0].neg} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_abort: busy=%b done=%b result=%h, required all zero",
                     cfg[0].busy, cfg[0].done, cfg[0].result);
        end
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (cfg[0].done || cfg[1].done || cfg[2].done) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL reset_abort_done: %0d done pulses, required 0", done_seen);
        end
    endtask

    task automatic test_latency;
        int bc0, bc1, bc2;
        bit s0, s1, s2;
        repeat (6) @(posedge clk);
        issue(1'b1, 16'h8000, 16'h0001);
        bc0 = 0; bc1 = 0; bc2 = 0;
        s0 = 0; s1 = 0; s2 = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (cfg[0].done) s0 = 1'b1; else if (!s0 && cfg[0].busy) bc0++;
            if (cfg[1].done) s1 = 1'b1; else if (!s1 && cfg[1].busy) bc1++;
            if (cfg[2].done) s2 = 1'b1; else if (!s2 && cfg[2].busy) bc2++;
        end
        tests_run++;
        if (!s0 || !s1 || !s2 || bc0 != 2 || bc1 != 1 || bc2 != 4) begin
            tests_failed++;
            $display("FAIL latency: busy cycles %0d/%0d/%0d done %b%b%b, required 2/1/4 done 111",
                     bc0, bc1, bc2, s0, s1, s2);
        end
        tests_run++;
        if (cfg[2].result !== 16'h7FFF || cfg[2].overflow !== 1'b1 || cfg[2].cout !== 1'b1) begin
            tests_failed++;
            $display("FAIL wide_min_minus_one: result=%h v=%b c=%b, required 7fff v=1 c=1",
                     cfg[2].result, cfg[2].overflow, cfg[2].cout);
        end
    endtask

    task automatic test_random;
        int target;
        target = cfg[0].accepted + 1000;
        for (int cyc = 0; cyc < 20000 && cfg[0].accepted < target; cyc++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 2) == 0);
            op    = 1'($urandom_range(0, 1));
            a_in  = 16'($urandom);
            b_in  = 16'($urandom);
        end
        start = 1'b0;
        repeat (8) @(posedge clk);
        tests_run++;
        if (cfg[0].accepted < target) begin
            tests_failed++;
            $display("FAIL random_count: %0d ops accepted, required %0d", cfg[0].accepted, target);
        end
        tests_run++;
        if (cfg[0].q.size() != 0 || cfg[1].q.size() != 0 || cfg[2].q.size() != 0) begin
            tests_failed++;
            $display("FAIL random_drain: pending %0d/%0d/%0d, required 0/0/0",
                     cfg[0].q.size(), cfg[1].q.size(), cfg[2].q.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_while_busy();
        test_reset_abort();
        test_latency();
        test_random();
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
